// File: rtl/gmii_pixel_depacketizer.sv
// gmii_pixel_depacketizer
// Parses GMII receive frames that carry video line segments. The header gives
// a line number (y) and a segment index (x). Payload bytes are paired and
// emitted as one-cycle FIFO write strobes. Good and bad packets are counted.
//
// Output handshake: fifo_wr_en is a valid-only strobe with no ready. Each high
// cycle carries one pixel pair on dout1/dout2, tagged with y_dout/x_dout. The
// downstream FIFO must accept it in that cycle. While the strobe is low, the
// data outputs hold their last values.
module gmii_pixel_depacketizer #(
  parameter logic [15:0] ETHTYPE = 16'h88B5,
  parameter int          PAIRS   = 320,
  parameter int          V_LINES = 720
) (
  input  logic        clk125m,
  input  logic        reset_n,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic [7:0]  rxd,
  output logic        fifo_wr_en,
  output logic [10:0] y_dout,
  output logic [1:0]  x_dout,
  output logic [7:0]  dout1,
  output logic [7:0]  dout2,
  output logic [15:0] pkt_cnt,
  output logic [15:0] err_cnt,
  output logic [2:0]  o_dbg_state
);

  localparam int PW = $clog2(PAIRS);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_HEADER   = 3'd2,
    S_PAYLOAD  = 3'd3,
    S_DROP     = 3'd4
  } state_t;

  logic          r_rst_sync;
  logic          w_rst_n;

  state_t        r_state,     w_state_nxt;
  logic [4:0]    r_idx,       w_idx_nxt;
  logic [7:0]    r_etype_hi,  w_etype_hi_nxt;
  logic [2:0]    r_y_hi,      w_y_hi_nxt;
  logic [10:0]   r_y,         w_y_nxt;
  logic [PW-1:0] r_pair,      w_pair_nxt;
  logic          r_phase,     w_phase_nxt;
  logic [7:0]    r_even,      w_even_nxt;
  logic          r_wr_en,     w_wr_en_nxt;
  logic [10:0]   r_y_dout,    w_y_dout_nxt;
  logic [1:0]    r_x_dout,    w_x_dout_nxt;
  logic [7:0]    r_dout1,     w_dout1_nxt;
  logic [7:0]    r_dout2,     w_dout2_nxt;
  logic [15:0]   r_pkt_cnt,   w_pkt_cnt_nxt;
  logic [15:0]   r_err_cnt,   w_err_cnt_nxt;
  logic          w_pkt_inc;
  logic          w_err_inc;
  logic [10:0]   w_y_cand;

  // Reset synchroniser. Assertion passes through asynchronously. Release is
  // retimed so that the logic first runs on the edge after the release edge.
  always_ff @(posedge clk125m or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= 1'b0;
    else          r_rst_sync <= 1'b1;
  end

  assign w_rst_n  = r_rst_sync;
  assign w_y_cand = {r_y_hi, rxd};

  // Register the FSM state together with its datapath and the counters.
  always_ff @(posedge clk125m or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_etype_hi <= '0;
      r_y_hi     <= '0;
      r_y        <= '0;
      r_pair     <= '0;
      r_phase    <= 1'b0;
      r_even     <= '0;
      r_wr_en    <= 1'b0;
      r_y_dout   <= '0;
      r_x_dout   <= '0;
      r_dout1    <= '0;
      r_dout2    <= '0;
      r_pkt_cnt  <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_etype_hi <= w_etype_hi_nxt;
      r_y_hi     <= w_y_hi_nxt;
      r_y        <= w_y_nxt;
      r_pair     <= w_pair_nxt;
      r_phase    <= w_phase_nxt;
      r_even     <= w_even_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_y_dout   <= w_y_dout_nxt;
      r_x_dout   <= w_x_dout_nxt;
      r_dout1    <= w_dout1_nxt;
      r_dout2    <= w_dout2_nxt;
      r_pkt_cnt  <= w_pkt_cnt_nxt;
      r_err_cnt  <= w_err_cnt_nxt;
    end
  end

  // Next-state and datapath decode. Every decision uses the byte sampled in
  // this cycle, and rx_er is checked before the data byte.
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_etype_hi_nxt = r_etype_hi;
    w_y_hi_nxt     = r_y_hi;
    w_y_nxt        = r_y;
    w_pair_nxt     = r_pair;
    w_phase_nxt    = r_phase;
    w_even_nxt     = r_even;
    w_wr_en_nxt    = 1'b0;
    w_y_dout_nxt   = r_y_dout;
    w_x_dout_nxt   = r_x_dout;
    w_dout1_nxt    = r_dout1;
    w_dout2_nxt    = r_dout2;
    w_pkt_inc      = 1'b0;
    w_err_inc      = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (rx_dv) w_state_nxt = (rxd == 8'h55) ? S_PREAMBLE : S_DROP;
      end

      S_PREAMBLE: begin
        if (!rx_dv) begin
          w_state_nxt = S_IDLE;
        end else if (rxd == 8'hD5) begin
          w_state_nxt = S_HEADER;
          w_idx_nxt   = '0;
        end else if (rxd != 8'h55) begin
          w_state_nxt = S_DROP;
        end
      end

      S_HEADER: begin
        if (!rx_dv) begin
          w_err_inc   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (rx_er) begin
          w_err_inc   = 1'b1;
          w_state_nxt = S_DROP;
        end else begin
          w_idx_nxt = r_idx + 5'd1;
          case (r_idx)
            5'd12: w_etype_hi_nxt = rxd;
            // Foreign EtherType is not an error: drop the frame without counting it.
            5'd13: if ({r_etype_hi, rxd} != ETHTYPE) w_state_nxt = S_DROP;
            5'd14: w_y_hi_nxt = rxd[2:0];
            5'd15: begin
              if (w_y_cand >= 11'(V_LINES)) begin
                w_err_inc   = 1'b1;
                w_state_nxt = S_DROP;
              end else begin
                w_y_nxt = w_y_cand;
              end
            end
            5'd16: begin
              w_y_dout_nxt = r_y;
              w_x_dout_nxt = rxd[1:0];
              w_pair_nxt   = '0;
              w_phase_nxt  = 1'b0;
              w_state_nxt  = S_PAYLOAD;
            end
            default: ;
          endcase
        end
      end

      S_PAYLOAD: begin
        if (!rx_dv) begin
          // Any latched even byte is discarded along with the frame.
          w_err_inc   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (rx_er) begin
          w_err_inc   = 1'b1;
          w_state_nxt = S_DROP;
        end else if (!r_phase) begin
          w_even_nxt  = rxd;
          w_phase_nxt = 1'b1;
        end else begin
          w_dout1_nxt = r_even;
          w_dout2_nxt = rxd;
          w_wr_en_nxt = 1'b1;
          w_phase_nxt = 1'b0;
          if (r_pair == PW'(PAIRS - 1)) begin
            w_pkt_inc   = 1'b1;
            w_state_nxt = S_DROP;
          end else begin
            w_pair_nxt = r_pair + 1'b1;
          end
        end
      end

      S_DROP: begin
        if (!rx_dv) w_state_nxt = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase

    w_pkt_cnt_nxt = (w_pkt_inc && (r_pkt_cnt != 16'hFFFF)) ? r_pkt_cnt + 16'd1 : r_pkt_cnt;
    w_err_cnt_nxt = (w_err_inc && (r_err_cnt != 16'hFFFF)) ? r_err_cnt + 16'd1 : r_err_cnt;
  end

  assign fifo_wr_en  = r_wr_en;
  assign y_dout      = r_y_dout;
  assign x_dout      = r_x_dout;
  assign dout1       = r_dout1;
  assign dout2       = r_dout2;
  assign pkt_cnt     = r_pkt_cnt;
  assign err_cnt     = r_err_cnt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_gmii_pixel_depacketizer.sv
// tb_gmii_pixel_depacketizer
// Directed frames drive the depacketizer. The expected pixel strobes are
// queued as each frame is sent, and a monitor compares them against the
// strobes the depacketizer actually produces.
module tb_gmii_pixel_depacketizer;

  localparam int PAIRS   = 320;
  localparam int V_LINES = 720;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rx_dv;
  logic        rx_er;
  logic [7:0]  rxd;
  logic        fifo_wr_en;
  logic [10:0] y_dout;
  logic [1:0]  x_dout;
  logic [7:0]  dout1;
  logic [7:0]  dout2;
  logic [15:0] pkt_cnt;
  logic [15:0] err_cnt;
  logic [2:0]  dbg_state;

  logic [28:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_strobe = 0;
  int          exp_strobes = 0;
  int          exp_pkt = 0;
  int          exp_err = 0;
  logic        prev_wr = 1'b0;

  gmii_pixel_depacketizer dut (
    .clk125m     (clk),
    .reset_n     (reset_n),
    .rx_dv       (rx_dv),
    .rx_er       (rx_er),
    .rxd         (rxd),
    .fifo_wr_en  (fifo_wr_en),
    .y_dout      (y_dout),
    .x_dout      (x_dout),
    .dout1       (dout1),
    .dout2       (dout2),
    .pkt_cnt     (pkt_cnt),
    .err_cnt     (err_cnt),
    .o_dbg_state (dbg_state)
  );

  // Clock: 125 MHz
  always #4 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one GMII byte time, changing inputs on the falling edge.
  task automatic drive(input logic dv, input logic er, input logic [7:0] d);
    @(negedge clk);
    rx_dv = dv;
    rx_er = er;
    rxd   = d;
  endtask

  // Send a frame and queue the strobes it should produce.
  // The payload byte at index i carries the value i[7:0]. If er_at >= 0,
  // rx_er is raised on that payload byte.
  task automatic send_frame(input logic [15:0] etype, input logic [10:0] y, input logic [1:0] x,
                            input int n_pay, input int er_at, input int n_fcs, input bit idle);
    if (etype == 16'h88B5) begin
      if (int'(y) >= V_LINES) begin
        exp_err++;
      end else begin
        for (int p = 0; p < PAIRS; p++) begin
          if ((2 * p + 1 < n_pay) && (er_at < 0 || 2 * p + 1 < er_at)) begin
            exp_q.push_back({y, x, 8'(2 * p), 8'(2 * p + 1)});
            exp_strobes++;
          end
        end
        if (n_pay >= 2 * PAIRS && (er_at < 0 || er_at >= 2 * PAIRS)) exp_pkt++;
        else exp_err++;
      end
    end
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < 12; i++) drive(1'b1, 1'b0, 8'(8'hA0 + i));
    drive(1'b1, 1'b0, etype[15:8]);
    drive(1'b1, 1'b0, etype[7:0]);
    drive(1'b1, 1'b0, {5'b0, y[10:8]});
    drive(1'b1, 1'b0, y[7:0]);
    drive(1'b1, 1'b0, {6'b0, x});
    for (int i = 0; i < n_pay; i++) drive(1'b1, (i == er_at), 8'(i));
    for (int i = 0; i < n_fcs; i++) drive(1'b1, 1'b0, 8'(8'hF0 + i));
    if (idle) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic post_check();
    repeat (3) drive(1'b0, 1'b0, 8'h00);
    check("queue_drained", exp_q.size(), 0);
    check("strobe_count", n_strobe, exp_strobes);
    check("pkt_cnt", {16'b0, pkt_cnt}, exp_pkt);
    check("err_cnt", {16'b0, err_cnt}, exp_err);
    check("state_idle", {29'b0, dbg_state}, 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_wr_en"}, {31'b0, fifo_wr_en}, 0);
    check({tag, "_y"}, {21'b0, y_dout}, 0);
    check({tag, "_x"}, {30'b0, x_dout}, 0);
    check({tag, "_d1"}, {24'b0, dout1}, 0);
    check({tag, "_d2"}, {24'b0, dout2}, 0);
    check({tag, "_pkt"}, {16'b0, pkt_cnt}, 0);
    check({tag, "_err"}, {16'b0, err_cnt}, 0);
    check({tag, "_state"}, {29'b0, dbg_state}, 0);
  endtask

  // Scoreboard monitor: pop one expected entry per strobe, sampled on the falling edge.
  always @(negedge clk) begin
    if (fifo_wr_en === 1'b1) begin
      check("no_back_to_back", {31'b0, prev_wr}, 0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL unexpected_strobe: observed %0h expected none", {y_dout, x_dout, dout1, dout2});
      end else begin
        check("strobe_data", {3'b0, y_dout, x_dout, dout1, dout2}, {3'b0, exp_q.pop_front()});
      end
      n_strobe++;
    end
    prev_wr = fifo_wr_en;
  end

  initial begin
    reset_n = 1'b0;
    rx_dv   = 1'b0;
    rx_er   = 1'b0;
    rxd     = 8'h00;
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    #2 reset_n = 1'b1;
    repeat (3) drive(1'b0, 1'b0, 8'h00);

    // Full frame, y = 719, x = 3
    send_frame(16'h88B5, 11'd719, 2'd3, 640, -1, 4, 1'b1);
    post_check();
    check("y_dout_719", {21'b0, y_dout}, 719);
    check("x_dout_3", {30'b0, x_dout}, 3);

    // Foreign EtherType
    send_frame(16'h0800, 11'd719, 2'd3, 640, -1, 4, 1'b1);
    post_check();

    // Line number out of range
    send_frame(16'h88B5, 11'd720, 2'd1, 640, -1, 4, 1'b1);
    post_check();

    // Abort after 101 payload bytes, then a back-to-back full frame
    send_frame(16'h88B5, 11'd10, 2'd2, 101, -1, 0, 1'b1);
    send_frame(16'h88B5, 11'd0, 2'd1, 640, -1, 4, 1'b1);
    post_check();
    check("y_dout_0", {21'b0, y_dout}, 0);
    check("x_dout_1", {30'b0, x_dout}, 1);

    // rx_er at payload byte 10
    send_frame(16'h88B5, 11'd300, 2'd0, 640, 10, 4, 1'b1);
    post_check();

    // Asynchronous reset in the middle of the payload
    send_frame(16'h88B5, 11'd123, 2'd2, 200, -1, 0, 1'b0);
    drive(1'b1, 1'b0, 8'd200);
    #3 reset_n = 1'b0;
    #1;
    check_zero_outputs("mid_reset");
    check("mid_reset_queue", exp_q.size(), 0);
    exp_pkt = 0;
    exp_err = 0;
    for (int i = 201; i < 204; i++) drive(1'b1, 1'b0, 8'(i));
    #2 reset_n = 1'b1;
    for (int i = 204; i < 640; i++) drive(1'b1, 1'b0, 8'(i));
    drive(1'b0, 1'b0, 8'h00);
    send_frame(16'h88B5, 11'd512, 2'd3, 640, -1, 4, 1'b1);
    post_check();
    check("y_dout_512", {21'b0, y_dout}, 512);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
